module_bounce_generator: RTL and testbench
==========================================

// Module: module_bounce_generator
// PURPOSE
//  Synthesizable mechanical-button emulator: converts a clean level request into a bouncy
//  bt_o waveform (burst of toggles, then a stable settle period).
//  Drives the bt1_i input of the debouncer for on-board and closed-loop tests, without a
//  physical push-button. A 16-bit LFSR randomizes the glitch widths; JITTER_BITS=0 gives
//  fully deterministic widths.
// PARAMETERS
//  MIN_W          4        minimum bounce segment width, clk cycles (>=1)
//  JITTER_BITS    0        random width span = 2**JITTER_BITS-1 cycles added to MIN_W (0..8)
//  BOUNCE_COUNT   2        number of glitch pairs per transition (0..255)
//  SETTLE_CYCLES  8        stable hold after last toggle before done_o (>=1)
//  LFSR_SEED      16'hACE1 LFSR reset value (must be non-zero)
// PORTS
//  clk       in   1   system clock
//  rst_i     in   1   synchronous reset, active-low
//  press_i   in   1   clean requested button level (1 = pressed)
//  bt_o      out  1   emulated bouncy button output (to debouncer bt1_i)
//  busy_o    out  1   high while a transition sequence is in progress
//  done_o    out  1   one-cycle pulse when bt_o has settled at the new level
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-low (rst_i). On rst_i=0 at a rising
//    edge: bt_o=0, busy_o=0, done_o=0, state=IDLE, lfsr=LFSR_SEED, counters cleared.
//  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, advances every cycle outside reset.
//  - Segment width W = MIN_W + lfsr[JITTER_BITS-1:0]; W = MIN_W when JITTER_BITS=0.
//    Sampled at each segment load. Segment counter is 16 bits.
//  - FSM states IDLE, BOUNCE, SETTLE; busy_o = (state != IDLE).
//  - IDLE: at edge N with press_i != bt_o:
//      bt_o <= press_i; tgl <= 2*BOUNCE_COUNT; cnt <= W-1; -> BOUNCE.
//    Otherwise hold.
//  - BOUNCE: cnt decrements each edge. At the edge where cnt==0:
//      - if tgl != 0: bt_o toggles, tgl--, cnt <= new W-1.
//      - if tgl == 0: cnt <= SETTLE_CYCLES-1, -> SETTLE.
//    Each bt_o level is therefore held exactly W cycles. The final level equals the target,
//    because an even number of toggles follows the first edge.
//  - SETTLE: bt_o is held. At the edge where cnt==0: -> IDLE and done_o <= 1 for one cycle.
//  - Latency, fixed widths: done_o rises at edge N + W*(2*BOUNCE_COUNT+1) + SETTLE_CYCLES.
//  - BOUNCE_COUNT=0: a single clean edge, followed by W + SETTLE_CYCLES hold before done_o.
//  - press_i changes while busy_o=1 are ignored; the target is latched at sequence start.
//    After return to IDLE, a mismatch with bt_o starts a new sequence at the next edge
//    (no dead cycle beyond the done_o cycle).
//  - Reset mid-sequence aborts immediately: bt_o=0 and the FSM is in IDLE after that edge.
//  - All outputs are registered; no combinational path from press_i to bt_o.
// TESTING
//  1 Reset: rst_i=0 for 3 cycles -> bt_o=0, busy_o=0, done_o=0; lfsr==16'hACE1.
//  2 Press, MIN_W=4, JITTER_BITS=0, BOUNCE_COUNT=2, SETTLE=8; press_i 0->1 sampled at edge N
//    -> bt_o levels 1,0,1,0,1 for 4 cycles each from edge N; bt_o stays 1;
//    done_o high for exactly 1 cycle after edge N+28; busy_o high from N to N+28.
//  3 Release with the same parameters -> mirrored pattern 0,1,0,1,0; done_o after N+28.
//  4 press_i pulsed 1->0 during BOUNCE -> sequence completes at 1 unchanged.
//    A release sequence starts at the edge after done_o; bt_o ends at 0.
//  5 rst_i=0 for 1 cycle at N+10 of scenario 2 -> bt_o=0, busy_o=0 next cycle; no done_o.
//  6 JITTER_BITS=3, 200 random transitions -> every bt_o level held between 4 and 11 cycles.
//    Final level always equals press_i; done_o count equals the transition count.
//    Drive bt_o into module_debouncer and check signal_o follows press_i with no glitches.

Source files
------------

// File: rtl/module_bounce_generator.sv
// ==== module_bounce_generator : clean level request -> bouncy button waveform (rev 1.0) ====
`default_nettype none

module module_bounce_generator #(
  parameter int          MIN_W         = 4,
  parameter int          JITTER_BITS   = 0,
  parameter int          BOUNCE_COUNT  = 2,
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst_i,
  input  logic press_i,
  output logic bt_o,
  output logic busy_o,
  output logic done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] C_MIN_W_M1  = 16'(MIN_W - 1);
  localparam logic [15:0] C_SETTLE_M1 = 16'(SETTLE_CYCLES - 1);
  localparam logic [8:0]  C_TOGGLES   = 9'(2 * BOUNCE_COUNT);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  tgl_q, tgl_d;
  logic        bt_q, bt_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic [15:0] w_width_m1;

  // Fibonacci LFSR, taps 16/14/13/11
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  generate
    if (JITTER_BITS == 0) begin : g_fixed
      assign w_width_m1 = C_MIN_W_M1;
    end else begin : g_jitter
      assign w_width_m1 = C_MIN_W_M1 + 16'(lfsr_q[JITTER_BITS-1:0]);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bt_d    = bt_q;
    cnt_d   = cnt_q;
    tgl_d   = tgl_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_i != bt_q) begin
          bt_d    = press_i;
          tgl_d   = C_TOGGLES;
          cnt_d   = w_width_m1;
          state_d = ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          if (tgl_q != 9'd0) begin
            bt_d  = ~bt_q;
            tgl_d = tgl_q - 9'd1;
            cnt_d = w_width_m1;
          end else begin
            cnt_d   = C_SETTLE_M1;
            state_d = ST_SETTLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= 16'd0;
      tgl_q   <= 9'd0;
      bt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      tgl_q   <= tgl_d;
      bt_q    <= bt_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

  assign bt_o   = bt_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_module_bounce_generator.sv
// ==== tb_module_bounce_generator : scoreboard bench for the button bounce emulator (rev 1.0) ====
`default_nettype none

module tb_module_bounce_generator;

  typedef struct packed {
    logic bt;
    logic busy;
    logic done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic press, bt, busy, done;
  logic press_j, bt_j, busy_j, done_j;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;

  logic mon_en        = 1'b0;
  logic mon_prev_bt   = 1'b0;
  logic mon_prev_busy = 1'b0;
  int   mon_run       = 0;
  int   done_cnt      = 0;

  module_bounce_generator u_dut (
    .clk     (clk),
    .rst_i   (rst_n),
    .press_i (press),
    .bt_o    (bt),
    .busy_o  (busy),
    .done_o  (done)
  );

  module_bounce_generator #(.JITTER_BITS(3)) u_jit (
    .clk     (clk),
    .rst_i   (rst_n),
    .press_i (press_j),
    .bt_o    (bt_j),
    .busy_o  (busy_j),
    .done_o  (done_j)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int val, input int lo, input int hi);
    n_total++;
    assert (val >= lo && val <= hi) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Expected per-cycle view of one fixed-width sequence (MIN_W=4, 2 glitch pairs, settle 8)
  function automatic void push_seq(input logic tgt, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (k < 28) begin
        e.bt   = (k < 20 && ((k / 4) % 2 == 1)) ? ~tgt : tgt;
        e.busy = 1'b1;
        e.done = 1'b0;
      end else begin
        e.bt   = tgt;
        e.busy = 1'b0;
        e.done = 1'b1;
      end
      q.push_back(e);
    end
  endfunction

  task automatic run_check(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        check("scoreboard_underflow", 16'd1, 16'd0);
      end else begin
        e = q.pop_front();
        check("bt_o", {15'd0, bt}, {15'd0, e.bt});
        check("busy_o", {15'd0, busy}, {15'd0, e.busy});
        check("done_o", {15'd0, done}, {15'd0, e.done});
      end
    end
  endtask

  // Width monitor for the jittered instance
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (bt_j !== mon_prev_bt) begin
        if (mon_prev_busy) check_range("seg_width", mon_run, 4, 11);
        mon_run = 1;
      end else begin
        mon_run++;
      end
      if (done_j === 1'b1) begin
        check_range("last_seg_plus_settle", mon_run - 1, 12, 19);
        done_cnt++;
      end
      mon_prev_bt   = bt_j;
      mon_prev_busy = busy_j;
    end
  end

  initial begin
    int k;
    rst_n   = 1'b0;
    press   = 1'b0;
    press_j = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_bt", {15'd0, bt}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_lfsr", u_dut.lfsr_q, 16'hACE1);
    rst_n = 1'b1;
    q.push_back(3'b000);
    run_check(1);

    // Press
    press = 1'b1;
    push_seq(1'b1, 29);
    q.push_back(3'b100);
    run_check(30);

    // Release
    press = 1'b0;
    push_seq(1'b0, 29);
    q.push_back(3'b000);
    run_check(30);

    // Press with a mid-bounce drop; release follows right after done
    press = 1'b1;
    push_seq(1'b1, 29);
    push_seq(1'b0, 29);
    q.push_back(3'b000);
    run_check(5);
    press = 1'b0;
    run_check(54);

    // Reset during bounce aborts the sequence
    press = 1'b1;
    push_seq(1'b1, 10);
    repeat (5) q.push_back(3'b000);
    run_check(10);
    rst_n = 1'b0;
    press = 1'b0;
    run_check(1);
    check("abort_lfsr", u_dut.lfsr_q, 16'hACE1);
    rst_n = 1'b1;
    run_check(4);
    check("scoreboard_drained", 16'(q.size()), 16'd0);

    // Jittered widths, random transitions
    @(negedge clk);
    mon_en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      press_j = ~press_j;
      k = 0;
      @(negedge clk);
      while (done_j !== 1'b1 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("jit_done_seen", {15'd0, done_j}, 16'd1);
      check("jit_final_level", {15'd0, bt_j}, {15'd0, press_j});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("jit_done_count", 16'(done_cnt), 16'd200);
    check("jit_idle_at_end", {15'd0, busy_j}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
